// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency meter with overflow/no-activity flags.
// Optional binary-to-BCD result (bcd_out) when FREQ_METER_BCD_EN is defined.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             no_activity
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [15:0]      bcd_out
`endif
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_CONVERT,
    S_REPORT
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             edge_pulse;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             overflow_q;
  logic             no_act_q;

  assign edge_pulse = s2_q & ~s3_q;

  // Saturating increment; an edge arriving at full scale marks the window as overflowed.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef FREQ_METER_BCD_EN
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift_d;
  logic [3:0]  step_q;
  logic [13:0] clamp_d;
  logic [31:0] cnt_ext;
  logic [15:0] bcd_out_q;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble step per cycle: correct each digit, then shift in the next binary bit.
  always_comb begin
    cnt_ext     = 32'(edge_cnt_d);
    clamp_d     = (cnt_ext > 32'd9999) ? 14'd9999 : 14'(edge_cnt_d);
    bcd_adj     = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_shift_d = (bcd_adj << 1) | {15'd0, bin_q[13]};
  end

  assign bcd_out = bcd_out_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      no_act_q   <= 1'b0;
`ifdef FREQ_METER_BCD_EN
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      bcd_out_q  <= '0;
`endif
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          gate_q     <= '0;
          edge_cnt_q <= '0;
          ovf_q      <= 1'b0;
          if (enable) state_q <= S_MEASURE;
        end
        S_MEASURE: begin
          if (!enable) begin
            state_q    <= S_IDLE;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end else begin
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            if (gate_q == GATE_LAST) begin
`ifdef FREQ_METER_BCD_EN
              state_q <= S_CONVERT;
              bin_q   <= clamp_d;
              bcd_q   <= '0;
              step_q  <= '0;
`else
              // Result registers load on the way into REPORT so they are valid with count_valid.
              state_q    <= S_REPORT;
              count_q    <= edge_cnt_d;
              overflow_q <= ovf_d;
              no_act_q   <= (edge_cnt_d == '0);
              valid_q    <= 1'b1;
`endif
            end else begin
              gate_q <= gate_q + GW'(1);
            end
          end
        end
`ifdef FREQ_METER_BCD_EN
        S_CONVERT: begin
          bcd_q  <= bcd_shift_d;
          bin_q  <= bin_q << 1;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd13) begin
            state_q    <= S_REPORT;
            count_q    <= edge_cnt_q;
            overflow_q <= ovf_q;
            no_act_q   <= (edge_cnt_q == '0);
            bcd_out_q  <= bcd_shift_d;
            valid_q    <= 1'b1;
          end
        end
`endif
        S_REPORT: begin
          gate_q     <= '0;
          edge_cnt_q <= '0;
          ovf_q      <= 1'b0;
          state_q    <= enable ? S_MEASURE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = overflow_q;
  assign no_activity = no_act_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter (default and FREQ_METER_BCD_EN builds).
module tb_freq_meter;

`ifdef FREQ_METER_BCD_EN
  localparam int DEAD = 15;
`else
  localparam int DEAD = 1;
`endif
  localparam int GATE_A = 1000;
  localparam int GATE_B = 100;
  localparam int PER_A  = GATE_A + DEAD;
  localparam int PER_B  = GATE_B + DEAD;

  logic        clk;
  logic        rst;
  logic        en_a, en_b;
  logic        sig_a, sig_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        vld_a, vld_b, ovf_a, ovf_b, noact_a, noact_b;
`ifdef FREQ_METER_BCD_EN
  logic        en_c, sig_c, vld_c, ovf_c, noact_c;
  logic [15:0] cnt_c, bcd_a, bcd_b, bcd_c;
`endif

  int per_a = 10;
  int per_b = 4;
  int ph_a, ph_b;
  int checks   = 0;
  int failures = 0;
  int cyc;
  int nvld;

  freq_meter #(.GATE_CYCLES(GATE_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .enable(en_a),
    .count(cnt_a), .count_valid(vld_a), .overflow(ovf_a), .no_activity(noact_a)
`ifdef FREQ_METER_BCD_EN
    , .bcd_out(bcd_a)
`endif
  );

  freq_meter #(.GATE_CYCLES(GATE_B), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .enable(en_b),
    .count(cnt_b), .count_valid(vld_b), .overflow(ovf_b), .no_activity(noact_b)
`ifdef FREQ_METER_BCD_EN
    , .bcd_out(bcd_b)
`endif
  );

`ifdef FREQ_METER_BCD_EN
  freq_meter #(.GATE_CYCLES(30000), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .sig_in(sig_c), .enable(en_c),
    .count(cnt_c), .count_valid(vld_c), .overflow(ovf_c), .no_activity(noact_c),
    .bcd_out(bcd_c)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square waves advance on the falling edge; period < 2 holds the line low.
  initial begin
    sig_a = 1'b0;
    sig_b = 1'b0;
    ph_a  = 0;
    ph_b  = 0;
`ifdef FREQ_METER_BCD_EN
    sig_c = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (per_a < 2) begin
        sig_a = 1'b0;
        ph_a  = 0;
      end else begin
        sig_a = (ph_a < per_a / 2);
        ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
      end
      if (per_b < 2) begin
        sig_b = 1'b0;
        ph_b  = 0;
      end else begin
        sig_b = (ph_b < per_b / 2);
        ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
      end
`ifdef FREQ_METER_BCD_EN
      sig_c = ~sig_c;
`endif
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_valid(input string tag, input int which, input int budget, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0: got = vld_a;
        1: got = vld_b;
`ifdef FREQ_METER_BCD_EN
        2: got = vld_c;
`endif
        default: got = 1'b0;
      endcase
    end
    chk(tag, int'(got), 1);
  endtask

  initial begin
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
`ifdef FREQ_METER_BCD_EN
    en_c = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_valid", int'(vld_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_noact", int'(noact_a), 0);
    chk("rst_count_b", int'(cnt_b), 0);
`ifdef FREQ_METER_BCD_EN
    chk("rst_bcd", int'(bcd_a), 0);
`endif

    // Small counter: 25 edges per window saturate a 4-bit count.
    rst  = 1'b0;
    en_b = 1'b1;
`ifdef FREQ_METER_BCD_EN
    en_c = 1'b1;
`endif
    wait_valid("b_wait1", 1, PER_B + 50, cyc);
    chk("b_startup", cyc, PER_B);
    chk("b_sat_count", int'(cnt_b), 15);
    chk("b_sat_ovf", int'(ovf_b), 1);
    chk("b_sat_noact", int'(noact_b), 0);
`ifdef FREQ_METER_BCD_EN
    chk("b_bcd", int'(bcd_b), 16'h0015);
`endif
    per_b = 50;
    wait_valid("b_wait2", 1, PER_B + 50, cyc);
    wait_valid("b_wait3", 1, PER_B + 50, cyc);
    chk("b_period", cyc, PER_B);
    chk("b_slow_count", int'(cnt_b), 2);
    chk("b_slow_ovf", int'(ovf_b), 0);
    chk("b_slow_noact", int'(noact_b), 0);
    en_b = 1'b0;

    // Main instance: period 10 over a 1000-cycle gate.
    en_a = 1'b1;
    wait_valid("a_wait1", 0, PER_A + 50, cyc);
    chk("a_startup", cyc, PER_A);
    chk_rng("a_first_count", int'(cnt_a), 99, 101);
    @(posedge clk);
    #1;
    chk("a_valid_one_cycle", int'(vld_a), 0);
    wait_valid("a_wait2", 0, PER_A + 50, cyc);
    chk("a_period", cyc, PER_A - 1);
    chk("a_count", int'(cnt_a), 100);
    chk("a_ovf", int'(ovf_a), 0);
    chk("a_noact", int'(noact_a), 0);
`ifdef FREQ_METER_BCD_EN
    chk("a_bcd", int'(bcd_a), 16'h0100);
`endif

    per_a = 0;
    wait_valid("a_wait3", 0, PER_A + 50, cyc);
    wait_valid("a_wait4", 0, PER_A + 50, cyc);
    chk("a_idle_count", int'(cnt_a), 0);
    chk("a_idle_noact", int'(noact_a), 1);
    chk("a_idle_ovf", int'(ovf_a), 0);

    per_a = 20;
    wait_valid("a_wait5", 0, PER_A + 50, cyc);
    chk_rng("a_p20_first", int'(cnt_a), 49, 51);
    chk("a_p20_noact", int'(noact_a), 0);
    wait_valid("a_wait6", 0, PER_A + 50, cyc);
    chk("a_p20_count", int'(cnt_a), 50);
`ifdef FREQ_METER_BCD_EN
    chk("a_p20_bcd", int'(bcd_a), 16'h0050);
`endif

    // Abort half-way through a window: nothing reported, result held.
    repeat (500) @(posedge clk);
    #1;
    en_a = 1'b0;
    nvld = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      if (vld_a) nvld++;
    end
    chk("abort_no_valid", nvld, 0);
    chk("abort_hold_count", int'(cnt_a), 50);
    en_a = 1'b1;
    wait_valid("a_wait7", 0, PER_A + 50, cyc);
    chk("abort_restart", cyc, PER_A);
    chk("abort_restart_count", int'(cnt_a), 50);

    // Reset in the middle of a window.
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_count", int'(cnt_a), 0);
    chk("midrst_valid", int'(vld_a), 0);
    chk("midrst_noact", int'(noact_a), 0);
    chk("midrst_ovf", int'(ovf_a), 0);
`ifdef FREQ_METER_BCD_EN
    chk("midrst_bcd", int'(bcd_a), 0);
`endif
    rst = 1'b0;
    wait_valid("a_wait8", 0, PER_A + 50, cyc);
    chk("midrst_restart", cyc, PER_A);
    chk_rng("midrst_count_after", int'(cnt_a), 49, 51);

`ifdef FREQ_METER_BCD_EN
    // Long gate: 15000 edges clamp to 9999 in BCD; count keeps the binary value.
    wait_valid("c_wait", 2, 31000, cyc);
    chk_rng("c_count", int'(cnt_c), 14999, 15001);
    chk("c_bcd", int'(bcd_c), 16'h9999);
    chk("c_ovf", int'(ovf_c), 0);
    chk("c_noact", int'(noact_c), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
